aes_key_expander: RTL
=====================

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 The block SHALL have one clock and reset is synchronous and active-high; ports SHALL be named clk and reset.
REQ-002 Port clk input 1 -- rising-edge clock for all state.
REQ-003 Port reset input 1 -- synchronous, active-high; sampled on clk rising edge.
REQ-004 Port init input 1 -- single-cycle request to expand key; honoured only when ready=1.
REQ-005 Port key input 256 -- cipher key; AES-128 uses key[255:128], and key[127:0] is ignored.
REQ-006 Port keylen input 1 -- 0 selects AES-128 (10 rounds), 1 selects AES-256 (14 rounds).
REQ-007 Port round input 4 -- round-key index requested by the encipher datapath.
REQ-008 Port round_key output 128 -- stored round key for index round.
REQ-009 Port ready output 1 -- 1 when idle and the key schedule is complete.
REQ-010 Port sboxw output 32 -- word sent to the shared external combinational S-box.
REQ-011 Port new_sboxw input 32 -- S-box result for sboxw, valid in the same cycle.

Function
REQ-012 Internal storage SHALL hold 15 x 128-bit round keys, index 0..14; num_rounds = 10 (keylen=0) or 14 (keylen=1).
REQ-013 The FSM SHALL have states IDLE, GENERATE and DONE.
REQ-014 IDLE, init=1: capture key and keylen, clear round_ctr to 0, load rcon=8'h01, ready<=0, go to GENERATE.
REQ-015 IDLE, init=0: hold; ready stays 1.
REQ-016 GENERATE: write exactly one round key per cycle to index round_ctr, then increment round_ctr.
REQ-017 GENERATE: after writing index num_rounds, go to DONE.
REQ-018 DONE: ready<=1, then go to IDLE.
REQ-019 Timing: with init sampled at edge T, ready SHALL be observed high after edge T+num_rounds+2, i.e. 12 cycles for AES-128 and 16 cycles for AES-256.
REQ-020 AES-128 schedule:
- index 0 = key[255:128].
- index i>0: t = RotWord(SubWord(w3 of prev)) ^ {rcon,24'h0}.
- w0 = p0^t, w1 = w0^p1, w2 = w1^p2, w3 = w2^p3 (p = previous round key).
REQ-021 AES-256 schedule:
- index 0 = key[255:128]; index 1 = key[127:0].
- index i>=2, even i: t = RotWord(SubWord(w3 of key i-1)) ^ {rcon,24'h0}.
- index i>=2, odd i: t = SubWord(w3 of key i-1), no rotation and no rcon.
- Words are chained as in REQ-020 against key i-2.
REQ-022 SubWord SHALL be computed via sboxw/new_sboxw; RotWord SHALL be applied as a left-rotate by 8 of new_sboxw.
REQ-023 sboxw SHALL be w3 of the most recently written key during GENERATE, and 32'h0 otherwise.
REQ-024 rcon SHALL advance by GF(2^8) doubling (xtime, poly 0x1b) after each use, giving 01,02,04,08,10,20,40,80,1b,36.
REQ-025 round_key SHALL be a combinational read of index round; round > 14 SHALL return 128'h0.
REQ-026 round_key content for indexes not yet written in the current expansion is undefined until ready=1.
REQ-027 init while ready=0 SHALL be ignored: no restart and no recapture of key or keylen.
REQ-028 A change of key or keylen after capture SHALL NOT affect the expansion in progress.
REQ-029 init in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.

Reset
REQ-030 reset=1 SHALL force: state IDLE, ready=1, round_ctr=0, rcon=8'h01, all 15 stored keys = 0, sboxw=0.
REQ-031 reset asserted mid-GENERATE SHALL abort the expansion; the next cycle obeys REQ-030, and init is honoured from the first cycle after reset deasserts.
REQ-032 reset SHALL take priority over init in the same cycle.

Verification
REQ-033 AES-128 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c (key[127:0]=0), init -> ready low for 11 cycles then high; round=1 -> a0fafe1788542cb123a339392a6c7605; round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round=1 -> 1f352c073b6108d72d9810a30914dff4; round=2 -> 9ba354118e6925afa51a8b5f2067fcde; round=14 -> fe4890d1e6188d0b046df344706c631e; ready high 16 cycles after init.
REQ-035 init pulsed again 3 cycles into an expansion with a different key -> ignored; final keys match the first key.
REQ-036 reset at cycle 5 of GENERATE -> next cycle ready=1, round=10 returns 0; a fresh init then completes correctly.
REQ-037 round=15 after any expansion -> round_key=0; sboxw=0 while ready=1.

Source files
------------

// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - key request, round-key readback and shared S-box port bundle
interface aes_key_expander_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128/256 key schedule, one round key per cycle via a shared S-box
module aes_key_expander (
    input  logic clk,
    input  logic reset,
    aes_key_expander_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GENERATE, DONE} state_t;

    state_t       state;
    state_t       state_next;

    logic [127:0] key_mem [0:14];
    logic [255:0] key_reg;
    logic         keylen_reg;
    logic [3:0]   round_ctr;
    logic [7:0]   rcon;
    logic         ready_reg;
    logic [127:0] last_key;
    logic [127:0] last2_key;

    logic [3:0]   num_rounds;
    logic         last_round;
    logic         use_rcon;
    logic [31:0]  sub_rot;
    logic [31:0]  t_word;
    logic [127:0] chain_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] new_key;
    logic [7:0]   rcon_next;

    assign num_rounds = keylen_reg ? 4'd14 : 4'd10;
    assign last_round = (round_ctr == num_rounds);
    assign rcon_next  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // SubWord and RotWord commute because both act bytewise, so rotating
    // the S-box output is equivalent to substituting the rotated word.
    assign sub_rot = {bus.new_sboxw[23:0], bus.new_sboxw[31:24]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.init) state_next = GENERATE;
            GENERATE: if (last_round) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        use_rcon  = 1'b0;
        t_word    = bus.new_sboxw;
        chain_key = last_key;
        if (!keylen_reg) begin
            use_rcon = (round_ctr != 4'd0);
            t_word   = sub_rot ^ {rcon, 24'h0};
        end else begin
            // AES-256 chains against the key two positions back.
            chain_key = last2_key;
            if (!round_ctr[0]) begin
                use_rcon = (round_ctr >= 4'd2);
                t_word   = sub_rot ^ {rcon, 24'h0};
            end
        end
        w0 = chain_key[127:96] ^ t_word;
        w1 = w0 ^ chain_key[95:64];
        w2 = w1 ^ chain_key[63:32];
        w3 = w2 ^ chain_key[31:0];
        if (round_ctr == 4'd0)
            new_key = key_reg[255:128];
        else if (keylen_reg && round_ctr == 4'd1)
            new_key = key_reg[127:0];
        else
            new_key = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg  <= 1'b1;
            round_ctr  <= 4'd0;
            rcon       <= 8'h01;
            key_reg    <= '0;
            keylen_reg <= 1'b0;
            last_key   <= '0;
            last2_key  <= '0;
            for (int i = 0; i < 15; i++)
                key_mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.init) begin
                        key_reg    <= bus.key;
                        keylen_reg <= bus.keylen;
                        round_ctr  <= 4'd0;
                        rcon       <= 8'h01;
                        ready_reg  <= 1'b0;
                    end
                end
                GENERATE: begin
                    key_mem[round_ctr] <= new_key;
                    last2_key          <= last_key;
                    last_key           <= new_key;
                    round_ctr          <= round_ctr + 4'd1;
                    if (use_rcon)
                        rcon <= rcon_next;
                end
                DONE: begin
                    ready_reg <= 1'b1;
                end
                default: begin
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.sboxw     = (state == GENERATE) ? last_key[31:0] : 32'h0;
    assign bus.round_key = (bus.round <= 4'd14) ? key_mem[bus.round] : 128'h0;
endmodule
